// File: rtl/fifo_ptr_pkg.sv
// Shared pointer helpers for the async FIFO: Gray/binary conversion and pointer width.
// Functions work on a maximum-width vector; callers zero-extend and truncate to their own width.
package fifo_ptr_pkg;

    localparam int PTR_MAX_W = 13;

    typedef logic [PTR_MAX_W-1:0] ptr_t;

    function automatic int ptr_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    function automatic ptr_t bin2gray(input ptr_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits contribute nothing to the XOR prefix, so narrower pointers decode correctly.
    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b = '0;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_gray_bus.sv
// Multi-flop synchronizer for a Gray-coded bus; only the last stage is meant to be consumed.
module sync_gray_bus #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fifo_wptr_full_ctrl.sv
// Write-side pointer and full/fill status for the async FIFO, fed by the read-domain Gray pointer.
module fifo_wptr_full_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int depthLog2        = 4,
    parameter int syncStages       = 2,
    parameter int almostFullThresh = 12,
    localparam int PW              = ptr_width(depthLog2)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 push__ENA,
    output logic                 push__RDY,
    input  logic [PW-1:0]        rptrGray,
    output logic [depthLog2-1:0] waddr,
    output logic [PW-1:0]        wptrGray,
    output logic                 full,
    output logic                 almostFull,
    output logic [PW-1:0]        fillLevel,
    output logic                 overflowErr,
    input  logic                 clearErr__ENA
);

    localparam logic [PW-1:0] DEPTH = PW'(1 << depthLog2);
    localparam logic [PW-1:0] AF_TH = PW'(almostFullThresh);

    logic [PW-1:0] rgray_sync;
    logic [PW-1:0] rbin_q;
    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wgray_q;
    logic          ovf_q;
    logic          accept;

    sync_gray_bus #(
        .WIDTH (PW),
        .STAGES(syncStages)
    ) u_rptr_sync (
        .clk_i (CLK),
        .rst_ni(nRST),
        .d_i   (rptrGray),
        .q_o   (rgray_sync)
    );

    // Status is derived from registers only, so no input reaches an output combinationally.
    assign fillLevel  = wbin_q - rbin_q;
    assign full       = (fillLevel == DEPTH);
    assign push__RDY  = !full;
    assign almostFull = (fillLevel >= AF_TH);
    assign accept     = push__ENA && !full;
    assign wbin_d     = wbin_q + PW'(1);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rbin_q  <= '0;
            wbin_q  <= '0;
            wgray_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            rbin_q <= PW'(gray2bin(ptr_t'(rgray_sync)));
            if (accept) begin
                wbin_q  <= wbin_d;
                wgray_q <= PW'(bin2gray(ptr_t'(wbin_d)));
            end
            // A fresh overflow outranks a clear in the same cycle.
            if (push__ENA && full) begin
                ovf_q <= 1'b1;
            end else if (clearErr__ENA) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign waddr       = wbin_q[depthLog2-1:0];
    assign wptrGray    = wgray_q;
    assign overflowErr = ovf_q;

endmodule

// File: doc/fifo_wptr_full_ctrl.md
Name: fifo_wptr_full_ctrl

Overview:
Write-side pointer/full-flag stage of the async FIFO, directly downstream of the read-domain Gray counter.
- Takes the remote read pointer (Gray, from the read-domain counter's readGray), synchronizes it into the write clock domain and decodes it to binary.
- Maintains the local write pointer in binary and registered Gray form.
- Produces full, almost-full and fill level, and gates push acceptance.

Parameters:
depthLog2, 4, log2 of FIFO depth; legal range 2..12; pointer width PW = depthLog2+1
syncStages, 2, number of synchronizer flops on the incoming Gray pointer; legal range 2..4
almostFullThresh, 12, fill level at or above which almostFull asserts; legal range 1..2^depthLog2

Ports:
CLK  in  1  write-domain clock
nRST  in  1  asynchronous active-low reset
push__ENA  in  1  request to write one entry this cycle
push__RDY  out  1  = !full; a push is accepted only when push__ENA && push__RDY
rptrGray  in  PW  read pointer in Gray code, from the read clock domain (asynchronous)
waddr  out  depthLog2  RAM write address = wbin[depthLog2-1:0]
wptrGray  out  PW  registered Gray write pointer, sent to the read-side synchronizer
full  out  1  FIFO full
almostFull  out  1  fillLevel >= almostFullThresh
fillLevel  out  PW  wbin - rbinQ mod 2^PW, range 0..2^depthLog2 (conservative)
overflowErr  out  1  sticky: set when a push is attempted while full
clearErr__ENA  in  1  clears overflowErr

Behaviour:
- Single clock CLK. Reset is asynchronous and active-low on nRST. Every flop clears to 0 immediately on nRST low, without waiting for a clock edge; this includes the sync chain.
- Reset values:
  - waddr=0, wptrGray=0, fillLevel=0.
  - full=0, push__RDY=1, almostFull=0, overflowErr=0.
- Synchronizer: syncStages flops in series on rptrGray. Only the last stage is consumed.
- Decode: rbinQ <= gray2bin(last sync stage), registered. A stable change on rptrGray becomes visible in rbinQ after syncStages+1 rising edges.
- Write pointer:
  - On an accepted push: wbin <= wbin+1 (mod 2^PW), and wptrGray <= bin2gray(wbin+1) on the same edge.
  - wptrGray is a direct flop output with no combinational logic behind it, and changes exactly one bit per push.
- Status (combinational from registers only; no input-to-output combinational path):
  - fillLevel = wbin - rbinQ (PW-bit modular subtraction).
  - full = (fillLevel == 2^depthLog2).
  - push__RDY = !full.
  - almostFull = (fillLevel >= almostFullThresh).
- Push while full: ignored; wbin and wptrGray are unchanged. overflowErr <= 1 on that edge.
- clearErr__ENA: overflowErr <= 0. If clearErr__ENA and an overflowing push occur in the same cycle, set wins.
- Wrap-around: pointers wrap 2^PW-1 -> 0 naturally. The extra MSB distinguishes full from empty.
- Simultaneous events: a push and a read-pointer advance in the same cycle are independent. The full state reflects both on the following cycles, with the read advance lagging by the sync latency. full never deasserts early, because the read side is seen late.
- The incoming Gray pointer is required to change at most one bit per read-clock edge. This is not checked.

Decomposition:
- Shared package fifo_ptr_pkg:
  - functions bin2gray and gray2bin, parameterized on width;
  - localparam helper for PW.
  The existing Gray counter and the read-side block reuse this package.
- Sub-module sync_gray_bus (width, stages): flop-chain synchronizer with async active-low reset. Reused for wptrGray on the read side.

Test Plan (depthLog2=2, syncStages=2, almostFullThresh=3 unless noted):
1. Reset: nRST=0 mid-simulation without clock -> wptrGray=000, full=0, push__RDY=1, fillLevel=000, overflowErr=0 immediately.
2. rptrGray=000 held, push 4 times -> wptrGray sequence 001,011,010,110; fillLevel 1,2,3,4; almostFull rises with fillLevel=3; full=1 and push__RDY=0 after the 4th push.
3. While full, push__ENA=1 for 1 cycle -> wptrGray stays 110 and overflowErr=1. clearErr__ENA then clears it. clearErr__ENA together with an overflowing push keeps overflowErr=1.
4. While full, set rptrGray=001 just after edge k -> full stays 1 through edges k+1 and k+2 and deasserts after edge k+3; fillLevel=3.
5. Wrap: 8 pushes with rptrGray tracking 2 entries behind -> wptrGray goes 000,001,011,010,110,111,101,100,000; exactly one bit changes per step; full never asserts.
6. Async reset with fillLevel=3 and the sync chain holding 101 -> all outputs and sync flops clear at once. After release, the first push gives wptrGray=001 and fillLevel=1.
